// File: rtl/gb_joypad.sv
// gb_joypad: Game Boy P1/JOYP register (0xFF00) driven by a SNES controller word.
// Buttons are remapped onto the eight Game Boy lines and debounced per line.
// The block also provides the P14/P15 matrix select, the joypad interrupt pulse
// and a soft-reset request when A+B+Select+Start is held long enough.
module gb_joypad #(
    parameter int DEBOUNCE_CYCLES = 4096,
    parameter int RESET_HOLD      = 4000000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] snes_buttons,
    input  logic [15:0] cpu_addr_bus,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_we,
    output logic [7:0]  data_out,
    output logic        data_hit,
    output logic [7:0]  irq,
    output logic        reset_req
);

    localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                HOLD_W    = $clog2(RESET_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RESET_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [15:0]       JOYP_ADDR = 16'hFF00;

    logic [7:0]        mapped;
    logic [7:0]        raw;
    logic [7:0]        db;
    logic [CNT_W-1:0]  cnt [8];
    logic [1:0]        sel;
    logic [3:0]        nib;
    logic [3:0]        prev_nib;
    logic              irq_joy;
    logic [HOLD_W-1:0] hold;
    logic              addr_hit;
    logic              sel_write;
    logic              combo_held;
    logic              unused_bits;

    // SNES bits with no Game Boy counterpart, and write bits outside P14/P15
    assign unused_bits = &{1'b0, snes_buttons[15:9], snes_buttons[1],
                           cpu_data_in[7:6], cpu_data_in[3:0]};

    // Line order is {Start, Select, B, A, Down, Up, Left, Right}, all active-low
    assign mapped = {snes_buttons[3], snes_buttons[2], snes_buttons[0], snes_buttons[8],
                     snes_buttons[5], snes_buttons[4], snes_buttons[6], snes_buttons[7]};

    assign addr_hit   = (cpu_addr_bus == JOYP_ADDR);
    assign sel_write  = cpu_we && addr_hit;
    assign combo_held = (db[7:4] == 4'b0000);
    assign irq        = {3'b000, irq_joy, 4'b0000};

    // Input register: the controller word is sampled every cycle
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            raw <= 8'hFF;
        end else begin
            raw <= mapped;
        end
    end

    // Per-line debounce: a new level is accepted only after it has been stable long enough
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            db <= 8'hFF;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (raw[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= raw[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Matrix select register, loaded from bits 5:4 of a write to 0xFF00
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sel <= 2'b11;
        end else if (sel_write) begin
            sel <= cpu_data_in[5:4];
        end
    end

    // Visible nibble: selected groups are ANDed, unselected groups read as released
    always_comb begin
        nib = 4'hF;
        if (!sel[0]) begin
            nib = nib & db[3:0];
        end
        if (!sel[1]) begin
            nib = nib & db[7:4];
        end
    end

    // Joypad interrupt: one-cycle pulse when any visible bit goes from 1 to 0
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            prev_nib <= 4'hF;
            irq_joy  <= 1'b0;
        end else begin
            prev_nib <= nib;
            irq_joy  <= |(prev_nib & ~nib);
        end
    end

    // Soft-reset combo timer: saturates so the request fires once per hold
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            hold      <= '0;
            reset_req <= 1'b0;
        end else begin
            reset_req <= combo_held && (hold == HOLD_LAST);
            if (!combo_held) begin
                hold <= '0;
            end else if (hold != HOLD_MAX) begin
                hold <= hold + HOLD_W'(1);
            end
        end
    end

    // Read path: register contents when addressed, open bus (0xFF) otherwise
    always_comb begin
        data_out = 8'hFF;
        data_hit = 1'b0;
        if (addr_hit) begin
            data_out = {2'b11, sel, nib};
            data_hit = 1'b1;
        end
    end

endmodule

// File: tb/tb_gb_joypad.sv
// tb_gb_joypad: randomized and directed stimulus for gb_joypad, checked every
// cycle against a behavioural model of the joypad register.
module tb_gb_joypad;

    localparam int DEB  = 4;
    localparam int HOLD = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] snes_buttons = 16'hFFFF;
    logic [15:0] cpu_addr_bus = 16'hFF00;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        cpu_we = 1'b0;
    logic [7:0]  data_out;
    logic        data_hit;
    logic [7:0]  irq;
    logic        reset_req;

    int tests_run = 0;
    int tests_failed = 0;
    int irq_pulses = 0;
    int rr_pulses = 0;
    int base;
    logic [15:0] btn;

    gb_joypad #(
        .DEBOUNCE_CYCLES(DEB),
        .RESET_HOLD(HOLD)
    ) dut (
        .clock(clock),
        .rst(rst),
        .snes_buttons(snes_buttons),
        .cpu_addr_bus(cpu_addr_bus),
        .cpu_data_in(cpu_data_in),
        .cpu_we(cpu_we),
        .data_out(data_out),
        .data_hit(data_hit),
        .irq(irq),
        .reset_req(reset_req)
    );

    always #5 clock = ~clock;

    // Game Boy line order {Start, Select, B, A, Down, Up, Left, Right}
    function automatic logic [7:0] mapButtons(input logic [15:0] s);
        return {s[3], s[2], s[0], s[8], s[5], s[4], s[6], s[7]};
    endfunction

    function automatic logic [3:0] visibleNibble(input logic [1:0] s, input logic [7:0] d);
        logic [3:0] n;
        n = 4'hF;
        if (!s[0]) n = n & d[3:0];
        if (!s[1]) n = n & d[7:4];
        return n;
    endfunction

    // Reference model: debounced level changes once the last DEB samples all agree
    logic [7:0] m_raw;
    logic [7:0] m_db;
    logic [1:0] m_sel;
    logic [3:0] m_prev;
    logic       m_irq;
    logic       m_rr;
    int         m_run;
    logic [7:0] m_hist[$];
    logic [3:0] cur_nib;
    logic [7:0] ones;
    logic [7:0] zeros;
    logic [7:0] new_db;

    always @(posedge clock or negedge rst) begin
        if (!rst) begin
            m_raw  = 8'hFF;
            m_db   = 8'hFF;
            m_sel  = 2'b11;
            m_prev = 4'hF;
            m_irq  = 1'b0;
            m_rr   = 1'b0;
            m_run  = 0;
            m_hist.delete();
        end else begin
            cur_nib = visibleNibble(m_sel, m_db);
            m_hist.push_back(m_raw);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            new_db = m_db;
            if (m_hist.size() == DEB) begin
                ones  = 8'hFF;
                zeros = 8'hFF;
                foreach (m_hist[j]) begin
                    ones  = ones & m_hist[j];
                    zeros = zeros & ~m_hist[j];
                end
                new_db = (m_db | ones) & ~zeros;
            end
            if (m_db[7:4] == 4'b0000) m_run++;
            else m_run = 0;
            m_rr   = (m_run == HOLD);
            m_irq  = |(m_prev & ~cur_nib);
            m_prev = cur_nib;
            if (cpu_we && cpu_addr_bus == 16'hFF00) m_sel = cpu_data_in[5:4];
            m_db  = new_db;
            m_raw = mapButtons(snes_buttons);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Compare every output against the model for the current address
    task automatic compareAll();
        logic [7:0] exp_data;
        exp_data = (cpu_addr_bus == 16'hFF00) ? {2'b11, m_sel, visibleNibble(m_sel, m_db)} : 8'hFF;
        checkOutput("data_out", 32'(data_out), 32'(exp_data));
        checkOutput("data_hit", 32'(data_hit), 32'(cpu_addr_bus == 16'hFF00));
        checkOutput("irq", 32'(irq), 32'({3'b000, m_irq, 4'b0000}));
        checkOutput("reset_req", 32'(reset_req), 32'(m_rr));
        if (irq[4]) irq_pulses++;
        if (reset_req) rr_pulses++;
    endtask

    task automatic applyStimulus(input logic [15:0] buttons, input logic [15:0] addr,
                                 input logic we, input logic [7:0] din);
        @(negedge clock);
        compareAll();
        snes_buttons = buttons;
        cpu_addr_bus = addr;
        cpu_we       = we;
        cpu_data_in  = din;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(btn, 16'hFF00, 1'b0, 8'h00);
    endtask

    task automatic writeSel(input logic [7:0] v);
        applyStimulus(btn, 16'hFF00, 1'b1, v);
    endtask

    int          k;
    logic [15:0] a;

    initial begin
        btn = 16'hFFFF;
        repeat (2) @(negedge clock);
        checkOutput("in_reset_data", 32'(data_out), 32'h00FF);
        rst = 1'b1;

        // Reset defaults
        idle(3);
        #1;
        checkOutput("reset_read", 32'(data_out), 32'h00FF);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_req_idle", 32'(reset_req), 32'h0);
        applyStimulus(btn, 16'hFF01, 1'b0, 8'h00);
        #1;
        checkOutput("miss_hit", 32'(data_hit), 32'h0);
        checkOutput("miss_data", 32'(data_out), 32'h00FF);

        // Direction select, press Right
        writeSel(8'h20);
        idle(2);
        base = irq_pulses;
        btn[BTN_RIGHT] = 1'b0;
        idle(10);
        #1;
        checkOutput("right_read", 32'(data_out), 32'h00EE);
        checkOutput("right_irq_count", 32'(irq_pulses - base), 32'd1);
        btn[BTN_RIGHT] = 1'b1;
        idle(8);

        // Glitch rejection on A with buttons selected
        writeSel(8'h10);
        idle(3);
        base = irq_pulses;
        btn[BTN_A] = 1'b0;
        idle(3);
        btn[BTN_A] = 1'b1;
        idle(8);
        #1;
        checkOutput("glitch_read", 32'(data_out), 32'h00DF);
        checkOutput("glitch_irq_count", 32'(irq_pulses - base), 32'd0);
        btn[BTN_A] = 1'b0;
        idle(4);
        btn[BTN_A] = 1'b1;
        idle(10);
        checkOutput("press4_irq_count", 32'(irq_pulses - base), 32'd1);

        // Select-induced interrupt
        writeSel(8'h30);
        base = irq_pulses;
        btn[BTN_A] = 1'b0;
        idle(8);
        #1;
        checkOutput("unselected_read", 32'(data_out), 32'h00FF);
        checkOutput("unselected_irq", 32'(irq_pulses - base), 32'd0);
        writeSel(8'h10);
        idle(1);
        #1;
        checkOutput("sel_write_read", 32'(data_out), 32'h00DE);
        idle(4);
        checkOutput("sel_irq_count", 32'(irq_pulses - base), 32'd1);

        // Both groups selected with A and Right held
        btn[BTN_RIGHT] = 1'b0;
        writeSel(8'h00);
        idle(8);
        #1;
        checkOutput("both_groups", 32'(data_out), 32'h00CE);

        // Soft-reset combo, held then re-armed
        base = rr_pulses;
        btn[BTN_B] = 1'b0;
        btn[BTN_SELECT] = 1'b0;
        btn[BTN_START] = 1'b0;
        idle(40);
        checkOutput("combo_pulses", 32'(rr_pulses - base), 32'd1);
        btn[BTN_START] = 1'b1;
        idle(6);
        btn[BTN_START] = 1'b0;
        idle(40);
        checkOutput("combo_rearm_pulses", 32'(rr_pulses - base), 32'd2);

        // Reset in the middle of a combo hold
        btn[BTN_START] = 1'b1;
        idle(6);
        btn[BTN_START] = 1'b0;
        idle(10);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_data", 32'(data_out), 32'h00FF);
        checkOutput("midrst_irq", 32'(irq), 32'h0);
        idle(2);
        rst = 1'b1;
        base = rr_pulses;
        idle(30);
        checkOutput("post_rst_pulses", 32'(rr_pulses - base), 32'd1);
        btn = 16'hFFFF;
        idle(8);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(0, 15);
                btn[k] = ~btn[k];
            end
            if ($urandom_range(0, 149) == 0) btn = btn & ~16'h010D;
            if ($urandom_range(0, 149) == 0) btn = 16'hFFFF;
            case ($urandom_range(0, 3))
                0, 1:    a = 16'hFF00;
                2:       a = 16'hFF01;
                default: a = 16'($urandom);
            endcase
            applyStimulus(btn, a, ($urandom_range(0, 7) == 0), 8'($urandom));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
